// File: rtl/mem_load_sequencer.sv
// mem_load_sequencer
//   Controls a six-entry register memory (`mem`, shared `load` enable).
//   Each pass does three things in order:
//     1. Collects DEPTH words from a valid/ready input stream into staging
//        registers that feed the memory's d0..d5 inputs.
//     2. Pulses `load` for one cycle so the memory captures the staging
//        words.
//     3. Streams the stored words back out of q0..q5 to a consumer over a
//        valid/ready handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   clr        in   synchronous active-high reset
//   start      in   begin a pass (only looked at in IDLE)
//   in_valid   in   upstream word valid
//   in_data    in   upstream word
//   in_ready   out  word accepted this cycle (FILL only)
//   load       out  memory load enable, single-cycle pulse
//   d0..d5     out  staging words to memory inputs
//   q0..q5     in   memory outputs
//   out_valid  out  out_data valid (DRAIN only)
//   out_data   out  drained word, q[out_idx]
//   out_idx    out  index 0..5 of out_data
//   out_ready  in   consumer accepts out_data
//   busy       out  high in every state except IDLE
//   done       out  single-cycle pulse at the end of a pass
//   err        out  single-cycle FILL timeout pulse
//
// Configuration
//   MEM_SEQ_TIMEOUT_EN: when defined, FILL gives up after TIMEOUT
//   consecutive cycles without in_valid. It pulses err, discards the
//   staged words, skips the load and returns to IDLE. When undefined,
//   err is tied low and FILL waits indefinitely.

module mem_load_sequencer #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned DEPTH   = 6,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             load,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] d4,
  output logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] q0,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  input  logic [WIDTH-1:0] q3,
  input  logic [WIDTH-1:0] q4,
  input  logic [WIDTH-1:0] q5,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_idx,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_COMMIT,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [2:0] LAST = 3'(DEPTH - 1);

  state_e                      state_q, state_d;
  logic [2:0]                  cnt_q,   cnt_d;
  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

`ifdef MEM_SEQ_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          timeout_hit;

  // Fires on the TIMEOUT-th consecutive FILL cycle without in_valid.
  assign timeout_hit = (state_q == ST_FILL) && !in_valid && (idle_q == IDLE_LAST);
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
`ifdef MEM_SEQ_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
`ifdef MEM_SEQ_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
`ifdef MEM_SEQ_TIMEOUT_EN
    idle_d  = idle_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          cnt_d   = '0;
`ifdef MEM_SEQ_TIMEOUT_EN
          idle_d  = '0;
`endif
        end
      end

      ST_FILL: begin
        // in_ready is unconditionally high here, so in_valid alone means
        // a word is accepted.
        if (in_valid) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cnt_q == 3'(i)) stage_d[i] = in_data;
          end
          if (cnt_q == LAST) begin
            state_d = ST_COMMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
`ifdef MEM_SEQ_TIMEOUT_EN
          idle_d = '0;
`endif
        end
`ifdef MEM_SEQ_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          stage_d = '0;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
`endif
      end

      ST_COMMIT: begin
        state_d = ST_DRAIN;
        cnt_d   = '0;
      end

      ST_DRAIN: begin
        if (out_ready) begin
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == ST_FILL);
    load      = (state_q == ST_COMMIT);
    out_valid = (state_q == ST_DRAIN);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    // cnt returns to 0 on every exit from FILL/DRAIN, so it can drive
    // out_idx directly. Outside DRAIN it then reads 0 / q0.
    out_idx   = cnt_q;
    unique case (cnt_q)
      3'd0:    out_data = q0;
      3'd1:    out_data = q1;
      3'd2:    out_data = q2;
      3'd3:    out_data = q3;
      3'd4:    out_data = q4;
      3'd5:    out_data = q5;
      default: out_data = q0;
    endcase
`ifdef MEM_SEQ_TIMEOUT_EN
    err = timeout_hit;
`else
    err = 1'b0;
`endif
  end

  assign d0 = stage_q[0];
  assign d1 = stage_q[1];
  assign d2 = stage_q[2];
  assign d3 = stage_q[3];
  assign d4 = stage_q[4];
  assign d5 = stage_q[5];

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Testbench for mem_load_sequencer.
//
// The bench contains a behavioural model of the six-entry register memory.
// Its contents are only written when load is high. Each word accepted on
// the input side is pushed to a scoreboard queue, and each drained word is
// popped from that queue and compared against it.
module tb_mem_load_sequencer;

  logic       clk = 1'b0;
  logic       clr, start, in_valid, out_ready;
  logic [4:0] in_data;
  logic       in_ready, load, out_valid, busy, done, err;
  logic [4:0] d0, d1, d2, d3, d4, d5;
  logic [4:0] q0, q1, q2, q3, q4, q5;
  logic [4:0] out_data;
  logic [2:0] out_idx;

  int compared   = 0;
  int mismatched = 0;

  // Scoreboard entries are {idx[2:0], data[4:0]}.
  logic [7:0] sb[$];

  // Memory model: initial contents are a known pattern, and there is no clear.
  logic [4:0] mem [6] = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25};

  always @(posedge clk) begin
    if (load) begin
      mem[0] <= d0; mem[1] <= d1; mem[2] <= d2;
      mem[3] <= d3; mem[4] <= d4; mem[5] <= d5;
    end
  end

  assign q0 = mem[0]; assign q1 = mem[1]; assign q2 = mem[2];
  assign q3 = mem[3]; assign q4 = mem[4]; assign q5 = mem[5];

  always #5 clk = ~clk;

  mem_load_sequencer #(.WIDTH(5), .DEPTH(6), .TIMEOUT(15)) dut (
    .clk(clk), .clr(clr), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .load(load),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_ready(out_ready), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One complete pass. Cycle 0 is the IDLE cycle with start high.
  task automatic do_pass(input logic [5:0][4:0] words, input bit toggle_valid,
                         input bit stall, input bit poke_start, input bit check_lat);
    int  c = 1;
    int  fi = 0;
    int  accepts = 0, loads = 0, dones = 0, stall_cnt = 0;
    int  load_cyc = -1, first_out = -1, done_cyc = -1;
    bit  fin = 0;
    logic [7:0] e;
    chk("idle_busy", busy, 0);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    while (!fin && c < 300) begin
      in_valid = toggle_valid ? (c % 2 == 1) : 1'b1;
      in_data  = 5'd0;
      if (fi < 6) in_data = words[fi];
      out_ready = 1'b1;
      if (stall && out_valid && out_idx == 3'd2 && stall_cnt < 3) begin
        out_ready = 1'b0;
        stall_cnt++;
      end
      start = poke_start && busy && (c % 2 == 0);
      chk("ready_valid_excl", in_ready && out_valid, 0);
      if (in_valid && in_ready) begin
        sb.push_back({3'(fi), in_data});
        fi++;
        accepts++;
      end
      if (load) begin
        loads++;
        load_cyc = c;
        chk("load_d0", d0, words[0]); chk("load_d1", d1, words[1]);
        chk("load_d2", d2, words[2]); chk("load_d3", d3, words[3]);
        chk("load_d4", d4, words[4]); chk("load_d5", d5, words[5]);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("sb_empty_at_out", 1, 0);
        end else begin
          e = sb[0];
          chk("out_idx", out_idx, e[7:5]);
          chk("out_data", out_data, e[4:0]);
          if (out_ready) begin
            void'(sb.pop_front());
            if (first_out < 0) first_out = c;
          end
        end
      end
      if (done) begin
        dones++;
        done_cyc = c;
        chk("done_busy", busy, 1);
        fin = 1;
      end
      cyc();
      c++;
    end
    start = 1'b0; in_valid = 1'b0;
    chk("pass_finished", fin, 1);
    chk("after_done_busy", busy, 0);
    chk("after_done_done", done, 0);
    cyc();
    if (done) dones++;
    chk("accept_count", accepts, 6);
    chk("load_count", loads, 1);
    chk("done_count", dones, 1);
    chk("sb_drained", sb.size(), 0);
    chk("stall_cycles", stall_cnt, stall ? 3 : 0);
    if (check_lat) begin
      chk("lat_load", load_cyc, 7);
      chk("lat_first_out", first_out, 8);
      chk("lat_done", done_cyc, 14);
    end
  endtask

  initial begin
    logic [5:0][4:0] w;
    logic [4:0]      mid [3];
    clr = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset: clr held for two cycles.
    cyc();
    cyc();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_load", load, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_data_q0", out_data, 20);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_d0", d0, 0);
    chk("rst_d5", d5, 0);
    chk("rst_q3_kept", q3, 23);
    clr = 1'b0;
    cyc();

    // Full pass with no stalls, including latency checks.
    w = {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    do_pass(w, 0, 0, 0, 1);
    chk("mem_after_pass1_q5", q5, 6);

    // Pass with toggled in_valid and a 3-cycle out_ready stall at idx 2.
    w = {5'd30, 5'd5, 5'd22, 5'd3, 5'd14, 5'd9};
    do_pass(w, 1, 1, 0, 0);

    // Mid-fill reset: accept three words, then clr.
    mid = '{5'd31, 5'd0, 5'd17};
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = mid[i];
      chk("mid_in_ready", in_ready, 1);
      chk("mid_no_load", load, 0);
      cyc();
    end
    in_valid = 1'b1; in_data = 5'd4; clr = 1'b1;
    chk("mid_busy_before_clr", busy, 1);
    cyc();
    clr = 1'b0; in_valid = 1'b0;
    chk("mid_busy_after_clr", busy, 0);
    chk("mid_in_ready_after_clr", in_ready, 0);
    chk("mid_load_after_clr", load, 0);
    chk("mid_stage_cleared", d0, 0);
    chk("mid_mem_kept_q0", q0, 9);
    chk("mid_mem_kept_q2", q2, 3);
    cyc();
    chk("mid_still_idle", busy, 0);

    // Follow-up pass of 7s, with start pulsed while busy.
    w = {6{5'd7}};
    do_pass(w, 0, 0, 1, 1);

`ifdef MEM_SEQ_TIMEOUT_EN
    // Timeout: two words accepted, then in_valid stays low.
    begin
      int idle_n = 0;
      int err_at = -1;
      int tl = 0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        in_valid = 1'b1; in_data = 5'd2;
        cyc();
      end
      in_valid = 1'b0;
      while (busy && idle_n < 40) begin
        idle_n++;
        if (load) tl++;
        if (err) err_at = idle_n;
        cyc();
      end
      chk("to_err_idle_cycle", err_at, 15);
      chk("to_back_idle", busy, 0);
      chk("to_no_load", tl, 0);
      chk("to_err_cleared", err, 0);
      chk("to_mem_kept_q0", q0, 7);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_load_sequencer.md
Name: mem_load_sequencer

Overview:
- Controller that sequences the six-entry, 5-bit register memory (`mem`).
- Gathers six words from a serial valid/ready input stream into staging registers, then drives the memory's shared `load` for exactly one cycle.
- Then reads the six stored words back out serially to a consumer over a valid/ready handshake.
- Sits between the upstream word source, the memory's d0..d5/q0..q5 buses and the downstream consumer.

Parameters:
- WIDTH, 5, bits per word (matches memory word width)
- DEPTH, 6, number of memory entries; fixed by the memory instance
- TIMEOUT, 15, idle cycles tolerated in FILL; used only with MEM_SEQ_TIMEOUT_EN

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  synchronous active-high reset
- start  in  1  begin a fill/commit/drain pass; sampled only in IDLE
- in_valid  in  1  upstream word valid
- in_data  in  WIDTH  upstream word
- in_ready  out  1  sequencer accepts in_data this cycle
- load  out  1  memory load enable, one-cycle pulse
- d0..d5  out  WIDTH each  staging words to memory d0..d5
- q0..q5  in  WIDTH each  memory outputs q0..q5
- out_valid  out  1  out_data valid
- out_data  out  WIDTH  word being drained
- out_idx  out  3  index (0..5) of out_data
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the pass completes
- err  out  1  one-cycle timeout pulse (0 unless MEM_SEQ_TIMEOUT_EN)

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - Reset is synchronous, active-high, on port `clr`.
- Reset state:
  - state=IDLE, cnt=0, stage0..5=0.
  - Outputs: in_ready=0, load=0, out_valid=0, out_idx=0, out_data=q0, busy=0, done=0, err=0.
- clr asserted in any state returns to the reset state at the next edge.
  - Memory contents are untouched, since the memory has no clear.
  - A partially filled stage is discarded, and load is never issued for it.
- d0..d5 are driven continuously from stage0..5.
- FSM states: IDLE, FILL, COMMIT, DRAIN, DONE.
  - IDLE: start=1 -> FILL, cnt=0. start is ignored in all other states.
  - FILL: in_ready=1.
    - On in_valid&in_ready: stage[cnt]<=in_data, cnt<=cnt+1.
    - Acceptance with cnt==DEPTH-1 -> COMMIT.
    - in_valid=0 holds state and cnt.
  - COMMIT: load=1 for this single cycle, in_ready=0, then -> DRAIN with cnt=0.
    - Memory captures stage at the end of this cycle, so q0..q5 hold the new words from the next cycle on.
  - DRAIN: out_valid=1, out_idx=cnt, out_data=q[cnt], combinational mux on the registered cnt.
    - On out_ready: cnt<=cnt+1.
    - Acceptance at cnt==DEPTH-1 -> DONE.
    - out_ready=0 stalls with out_data/out_idx stable.
  - DONE: done=1 for one cycle, busy=1 -> IDLE.
    - start in DONE is ignored; a new pass needs start in IDLE.
- Latency with in_valid=1 and out_ready=1 throughout, start at cycle 0:
  - FILL cycles 1-6.
  - COMMIT/load cycle 7.
  - out words cycles 8-13.
  - done cycle 14.
  - IDLE cycle 15.
- cnt is 3 bits and never exceeds DEPTH-1; there is no wrap-around beyond 5.
- in_ready and out_valid are never high in the same cycle.

Optional Feature:
- Macro: MEM_SEQ_TIMEOUT_EN.
- Defined:
  - An idle counter clears on every FILL acceptance and on FILL entry.
  - It increments in each FILL cycle with in_valid=0.
  - On reaching TIMEOUT: err=1 for one cycle, the stage is discarded, load is not issued, and the FSM returns to IDLE.
  - DRAIN has no timeout.
- Undefined: no counter logic exists, err is tied 0, and FILL waits indefinitely.

Test Plan:
- Reset: assert clr 2 cycles -> all outputs 0, busy=0, in_ready=0; q unchanged.
- Full pass, no stalls: start, feed 1,2,3,4,5,6 back-to-back, out_ready=1.
  - load high only at cycle 7 with d0..d5=1..6.
  - out_data 1..6 with out_idx 0..5 at cycles 8-13.
  - done at cycle 14.
- Stalls: in_valid toggled 1/0 and out_ready low 3 cycles at idx 2.
  - Exactly 6 accepts, one load pulse.
  - out_data=3 held stable during the stall.
  - Drain order preserved.
- Mid-fill reset: accept 31,0,17, then clr -> IDLE next edge, no load pulse.
  - A following pass with 7,7,7,7,7,7 reads back six 7s.
- start ignored while busy: pulse start during FILL, DRAIN and DONE -> no state change, exactly one done per pass.
- With MEM_SEQ_TIMEOUT_EN, TIMEOUT=15: accept 2 words, then in_valid=0 -> err pulse after 15 idle cycles, back in IDLE, no load, memory retains prior contents.
